// File: rtl/uart_pkg.sv
// Shared UART constants (also used by the transmitter's divider) and receiver state encoding.
package uart_pkg;

  localparam int unsigned CLK_HZ       = 100_000_000;
  localparam int unsigned BAUD         = 115_200;
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous idle-high input; resets to 1.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Falling-edge clocked so it lines up with the rest of the UART.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-entry output register with ready/read
// handshake, framing-error pulse and sticky overrun flag.
module uart_rx import uart_pkg::*; #(
  parameter int unsigned ClkHz = CLK_HZ,
  parameter int unsigned Baud  = BAUD
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_rdy_o,
  output logic       uart_ferr_o,
  output logic       uart_ovr_o,
  output logic       uart_busy_o
);

  localparam int unsigned ClksPerBit = ClkHz / Baud;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);

  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);

  logic            rx_s;
  logic            rx_q;
  logic [1:0]      arm_q;
  rx_state_t       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  logic            fall;
  logic            cnt_half;
  logic            cnt_bit;
  logic            done;
  logic            rd_ok;

  uart_sync2 u_sync (
    .clk_i  (sys_clk_i),
    .rst_ni (sys_rst_n_i),
    .d_i    (uart_rx_i),
    .q_o    (rx_s)
  );

  // Edges are ignored until rx_s and rx_q both carry real line samples, so the
  // synchronizer's reset value of 1 cannot fake a start edge on a line held low.
  assign fall     = (arm_q == 2'd3) && rx_q && !rx_s;
  assign cnt_half = (cnt_q == HalfLast);
  assign cnt_bit  = (cnt_q == BitLast);
  assign done     = (state_q == StStop) && cnt_bit && rx_s;
  assign rd_ok    = uart_rd_i && uart_rdy_o;

  always_ff @(negedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_q        <= 1'b1;
      arm_q       <= 2'd0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      uart_dat_o  <= 8'h00;
      uart_rdy_o  <= 1'b0;
      uart_ferr_o <= 1'b0;
      uart_ovr_o  <= 1'b0;
      uart_busy_o <= 1'b0;
    end else begin
      rx_q        <= rx_s;
      uart_ferr_o <= 1'b0;
      cnt_q       <= cnt_q + CntW'(1);
      if (arm_q != 2'd3) begin
        arm_q <= arm_q + 2'd1;
      end

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (fall) begin
            state_q     <= StStart;
            uart_busy_o <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_half) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= StData;
              bit_idx_q <= 3'd0;
            end else begin
              state_q     <= StIdle;
              uart_busy_o <= 1'b0;
            end
          end
        end
        StData: begin
          if (cnt_bit) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end
        end
        StStop: begin
          if (cnt_bit) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q     <= StIdle;
              uart_busy_o <= 1'b0;
            end else begin
              state_q     <= StBreak;
              uart_ferr_o <= 1'b1;
            end
          end
        end
        StBreak: begin
          cnt_q <= '0;
          if (rx_s) begin
            state_q     <= StIdle;
            uart_busy_o <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          cnt_q       <= '0;
          uart_busy_o <= 1'b0;
        end
      endcase

      // A completing byte takes priority over a read in the same cycle.
      if (done) begin
        if (!uart_rdy_o || uart_rd_i) begin
          uart_dat_o <= shift_q;
          uart_rdy_o <= 1'b1;
        end else begin
          uart_ovr_o <= 1'b1;
        end
      end else if (rd_ok) begin
        uart_rdy_o <= 1'b0;
        uart_ovr_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx, run at 50 clocks per bit to keep frames short.
module tb_uart_rx;

  localparam int unsigned ClkHz = 100_000_000;
  localparam int unsigned Baud  = 2_000_000;
  localparam int CPB  = ClkHz / Baud;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + 1 + HALF + 9 * CPB;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx    = 1'b1;
  logic       rd    = 1'b0;
  logic [7:0] dat;
  logic       rdy;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .ClkHz (ClkHz),
    .Baud  (Baud)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .uart_rx_i   (rx),
    .uart_rd_i   (rd),
    .uart_dat_o  (dat),
    .uart_rdy_o  (rdy),
    .uart_ferr_o (ferr),
    .uart_ovr_o  (ovr),
    .uart_busy_o (busy)
  );

  // Output activity monitor, sampled on the rising edge (DUT state moves on the falling edge).
  logic prev_rdy    = 1'b0;
  int   rise_cnt    = 0;
  int   ferr_cycles = 0;
  int   busy_cycles = 0;
  time  rise_t      = 0;
  time  start_t     = 0;

  always @(posedge clk) begin
    prev_rdy <= rdy;
    if (rdy === 1'b1 && prev_rdy === 1'b0) begin
      rise_cnt <= rise_cnt + 1;
      rise_t   <= $time;
    end
    if (ferr === 1'b1) ferr_cycles <= ferr_cycles + 1;
    if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int cpb, input bit stop);
    @(posedge clk);
    rx      = 1'b0;
    start_t = $time;
    repeat (cpb) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (cpb) @(posedge clk);
    end
    rx = stop;
    repeat (cpb) @(posedge clk);
  endtask

  task automatic do_read();
    rd = 1'b1;
    @(posedge clk);
    rd = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    int         cpb;
    bit         rd_after;
    logic [7:0] exp_dat;
    bit         exp_rdy;
    bit         exp_ovr;
  } vec_t;

  vec_t vecs [10];

  logic [7:0] dat_m;
  bit         rdy_m;
  bit         ovr_m;

  initial begin
    int fc;
    int rc;
    int bc;

    vecs[0] = '{8'hA5, CPB,     1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, CPB,     1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, CPB,     1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h00, CPB - 1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, CPB - 1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h00, CPB + 1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, CPB + 1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h11, CPB,     1'b0, 8'h11, 1'b1, 1'b0};
    vecs[8] = '{8'h22, CPB,     1'b1, 8'h11, 1'b1, 1'b1};
    vecs[9] = '{8'hC3, CPB,     1'b1, 8'hC3, 1'b1, 1'b0};

    // Reset values
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check("reset dat", dat, 8'h00);
    check("reset rdy", rdy, 1'b0);
    check("reset ferr", ferr, 1'b0);
    check("reset ovr", ovr, 1'b0);
    check("reset busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Directed frames, back-to-back with reads in between
    for (int i = 0; i < 10; i++) begin
      fc = ferr_cycles;
      send_frame(vecs[i].data, vecs[i].cpb, 1'b1);
      check($sformatf("vec%0d dat", i), dat, vecs[i].exp_dat);
      check($sformatf("vec%0d rdy", i), rdy, vecs[i].exp_rdy);
      check($sformatf("vec%0d ovr", i), ovr, vecs[i].exp_ovr);
      check($sformatf("vec%0d ferr", i), ferr_cycles - fc, 0);
      if (i == 0) check_range("latency", int'((rise_t - start_t) / 10), LAT - 2, LAT + 2);
      if (vecs[i].rd_after) begin
        do_read();
        check($sformatf("vec%0d rdy after read", i), rdy, 1'b0);
        check($sformatf("vec%0d ovr after read", i), ovr, 1'b0);
      end
    end

    // Short low glitch on an idle line
    repeat (2 * CPB) @(posedge clk);
    fc = ferr_cycles;
    rc = rise_cnt;
    bc = busy_cycles;
    @(posedge clk);
    rx = 1'b0;
    repeat (HALF / 2) @(posedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check("glitch busy", busy, 1'b0);
    check("glitch rdy", rdy, 1'b0);
    check("glitch ovr", ovr, 1'b0);
    check("glitch ferr", ferr_cycles - fc, 0);
    check("glitch rise", rise_cnt - rc, 0);
    check_range("glitch busy len", busy_cycles - bc, HALF - 2, HALF + 2);

    // Framing error: stop bit low, line held low for three bit-times in total
    fc = ferr_cycles;
    send_frame(8'h3C, CPB, 1'b0);
    repeat (2 * CPB) @(posedge clk);
    check("ferr pulse", ferr_cycles - fc, 1);
    check("ferr rdy", rdy, 1'b0);
    check("ferr dat kept", dat, 8'hC3);
    check("ferr break busy", busy, 1'b1);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    check("break exit busy", busy, 1'b0);
    send_frame(8'h81, CPB, 1'b1);
    check("after break dat", dat, 8'h81);
    check("after break rdy", rdy, 1'b1);
    do_read();

    // Read landing in the exact cycle a second byte completes
    send_frame(8'h11, CPB, 1'b1);
    check("pre-collide rdy", rdy, 1'b1);
    fork
      send_frame(8'h22, CPB, 1'b1);
      begin
        repeat (LAT) @(posedge clk);
        rd = 1'b1;
        @(posedge clk);
        rd = 1'b0;
      end
    join
    check("collide dat", dat, 8'h22);
    check("collide rdy", rdy, 1'b1);
    check("collide ovr", ovr, 1'b0);

    // Reset in mid-DATA (bit 3 of 0x96 is low), released with the line still low
    @(posedge clk);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    rx = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check("mid reset dat", dat, 8'h00);
    check("mid reset rdy", rdy, 1'b0);
    fc = ferr_cycles;
    rc = rise_cnt;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("post reset dat", dat, 8'h00);
    check("post reset rdy", rdy, 1'b0);
    check("post reset ovr", ovr, 1'b0);
    check("post reset busy", busy, 1'b0);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    check("post reset no byte", rise_cnt - rc, 0);
    check("post reset no ferr", ferr_cycles - fc, 0);
    send_frame(8'h5A, CPB, 1'b1);
    check("post reset frame dat", dat, 8'h5A);
    check("post reset frame rdy", rdy, 1'b1);
    do_read();
    check("post reset read rdy", rdy, 1'b0);

    // Random frames against a byte-level handshake model
    dat_m = 8'h5A;
    rdy_m = 1'b0;
    ovr_m = 1'b0;
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      int         cpb;
      int         gap;
      bit         rdb;
      d   = 8'($urandom_range(0, 255));
      cpb = int'($urandom_range(CPB - 1, CPB + 1));
      gap = int'($urandom_range(0, 20));
      rdb = 1'($urandom_range(0, 1));
      send_frame(d, cpb, 1'b1);
      if (!rdy_m) begin
        dat_m = d;
        rdy_m = 1'b1;
      end else begin
        ovr_m = 1'b1;
      end
      check($sformatf("rand%0d dat", n), dat, dat_m);
      check($sformatf("rand%0d rdy", n), rdy, rdy_m);
      check($sformatf("rand%0d ovr", n), ovr, ovr_m);
      if (rdb) begin
        do_read();
        rdy_m = 1'b0;
        ovr_m = 1'b0;
        check($sformatf("rand%0d rdy after read", n), rdy, rdy_m);
        check($sformatf("rand%0d ovr after read", n), ovr, ovr_m);
      end
      repeat (gap) @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
